// File: rtl/alu_exec_cluster.sv
// Three-lane ALU issue receiver with per-lane result FIFOs and a round-robin CDB writeback arbiter.
// Optional second writeback port when CDB_DUAL_WB_EN is defined.
module alu_exec_cluster #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  issue_valid,
    input  logic [11:0] optype_issue,
    input  logic [95:0] PC_issue,
    input  logic [95:0] srcReg1_data_issue,
    input  logic [95:0] srcReg2_data_issue,
    input  logic [95:0] imm_issue,
    input  logic [17:0] destReg_issue,
    input  logic [47:0] ROBNum_issue,
    output logic        FU_ready_ALU0_out,
    output logic        FU_ready_ALU1_out,
    output logic        FU_ready_ALU2_out,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [1:0]  wb_lane,
    output logic [31:0] wb_result,
    output logic [5:0]  wb_destReg,
    output logic [15:0] wb_ROBNum,
    output logic [31:0] wb_PC,
    output logic        wb_rd_en,
    output logic        wb_is_mem,
    output logic [31:0] wb_store_data,
`ifdef CDB_DUAL_WB_EN
    output logic        wb1_valid,
    input  logic        wb1_ready,
    output logic [1:0]  wb1_lane,
    output logic [31:0] wb1_result,
    output logic [5:0]  wb1_destReg,
    output logic [15:0] wb1_ROBNum,
    output logic [31:0] wb1_PC,
    output logic        wb1_rd_en,
    output logic        wb1_is_mem,
    output logic [31:0] wb1_store_data,
`endif
    output logic        illegal_op
);
    typedef struct packed {
        logic [31:0] result;
        logic [5:0]  dest;
        logic [15:0] rob;
        logic [31:0] pc;
        logic        rd_en;
        logic        is_mem;
        logic [31:0] sdata;
    } wb_entry_t;

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    logic [2:0]            fu_ready, nonempty, bad, pop;
    wb_entry_t [2:0]       head;
    logic [1:0]            ptr, g0, lock_lane;
    logic                  v0, locked;

    function automatic logic [1:0] rr_add(input logic [1:0] p, input int i);
        int s;
        s = (int'(p) + i) % 3;
        return 2'(s);
    endfunction

    function automatic wb_entry_t pick(input wb_entry_t [2:0] h, input logic [1:0] l);
        case (l)
            2'd1:    return h[1];
            2'd2:    return h[2];
            default: return h[0];
        endcase
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_lane
        logic [31:0]   s1, s2, imm;
        logic [3:0]    op;
        wb_entry_t     e;
        logic          lgl, accept, push;
        wb_entry_t     mem [FIFO_DEPTH];
        logic [PW-1:0] rp, wp;
        logic [CW-1:0] cnt;

        assign s1  = srcReg1_data_issue[32*k +: 32];
        assign s2  = srcReg2_data_issue[32*k +: 32];
        assign imm = imm_issue[32*k +: 32];
        assign op  = optype_issue[4*k +: 4];

        always_comb begin
            e        = '0;
            lgl      = 1'b1;
            e.dest   = destReg_issue[6*k +: 6];
            e.rob    = ROBNum_issue[16*k +: 16];
            e.pc     = PC_issue[32*k +: 32];
            e.rd_en  = 1'b1;
            case (op)
                4'd1:        e.result = s1 + s2;
                4'd2:        e.result = s1 + imm;
                4'd3:        e.result = imm;
                4'd4:        e.result = s1 | imm;
                4'd5:        e.result = s1 ^ s2;
                4'd6:        e.result = $signed(s1) >>> imm[4:0];
                4'd7, 4'd8: begin
                    e.result = s1 + imm;
                    e.is_mem = 1'b1;
                end
                4'd9, 4'd10: begin
                    e.result = s1 + imm;
                    e.is_mem = 1'b1;
                    e.rd_en  = 1'b0;
                    e.sdata  = s2;
                end
                default: begin
                    lgl     = 1'b0;
                    e.rd_en = 1'b0;
                end
            endcase
        end

        // Readiness comes only from the registered count, never from wb_ready.
        assign fu_ready[k] = !rst && (cnt < DEPTH_C);
        assign accept      = issue_valid[k] && fu_ready[k];
        assign push        = accept && lgl;
        assign bad[k]      = accept && !lgl;
        assign nonempty[k] = (cnt != '0);
        assign head[k]     = mem[rp];

        always_ff @(posedge clk) begin
            if (push) mem[wp] <= e;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rp  <= '0;
                wp  <= '0;
                cnt <= '0;
            end else begin
                if (push)   wp <= (wp == LAST) ? '0 : wp + PW'(1);
                if (pop[k]) rp <= (rp == LAST) ? '0 : rp + PW'(1);
                case ({push, pop[k]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign FU_ready_ALU0_out = fu_ready[0];
    assign FU_ready_ALU1_out = fu_ready[1];
    assign FU_ready_ALU2_out = fu_ready[2];

    // A stalled grant stays locked so the presented entry cannot shift to a newly filled lane.
    always_comb begin
        g0 = lock_lane;
        v0 = locked;
        if (!locked) begin
            for (int i = 0; i < 3; i++) begin
                if (!v0 && nonempty[rr_add(ptr, i)]) begin
                    g0 = rr_add(ptr, i);
                    v0 = 1'b1;
                end
            end
        end
    end

    wb_entry_t e0;
    assign e0            = v0 ? pick(head, g0) : '0;
    assign wb_valid      = v0;
    assign wb_lane       = v0 ? g0 : 2'd0;
    assign wb_result     = e0.result;
    assign wb_destReg    = e0.dest;
    assign wb_ROBNum     = e0.rob;
    assign wb_PC         = e0.pc;
    assign wb_rd_en      = e0.rd_en;
    assign wb_is_mem     = e0.is_mem;
    assign wb_store_data = e0.sdata;

`ifdef CDB_DUAL_WB_EN
    logic [1:0] g1;
    logic       v1;
    wb_entry_t  e1;

    always_comb begin
        g1 = 2'd0;
        v1 = 1'b0;
        for (int i = 1; i < 3; i++) begin
            if (v0 && !v1 && nonempty[rr_add(g0, i)]) begin
                g1 = rr_add(g0, i);
                v1 = 1'b1;
            end
        end
    end

    assign e1             = v1 ? pick(head, g1) : '0;
    assign wb1_valid      = v1;
    assign wb1_lane       = v1 ? g1 : 2'd0;
    assign wb1_result     = e1.result;
    assign wb1_destReg    = e1.dest;
    assign wb1_ROBNum     = e1.rob;
    assign wb1_PC         = e1.pc;
    assign wb1_rd_en      = e1.rd_en;
    assign wb1_is_mem     = e1.is_mem;
    assign wb1_store_data = e1.sdata;

    always_comb begin
        pop = '0;
        if (v0 && wb_ready)  pop = pop | (3'b001 << g0);
        if (v1 && wb1_ready) pop = pop | (3'b001 << g1);
    end
`else
    always_comb begin
        pop = '0;
        if (v0 && wb_ready) pop = 3'b001 << g0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 2'd0;
            locked     <= 1'b0;
            lock_lane  <= 2'd0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= |bad;
            locked     <= v0 && !wb_ready;
            lock_lane  <= g0;
`ifdef CDB_DUAL_WB_EN
            if (v1 && wb1_ready)     ptr <= rr_add(g1, 1);
            else if (v0 && wb_ready) ptr <= rr_add(g0, 1);
`else
            if (v0 && wb_ready) ptr <= rr_add(g0, 1);
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_cluster.sv
// Self-checking bench for alu_exec_cluster: directed scenarios plus randomized traffic
// checked against a queue-based reference model of lanes and round-robin writeback.
module tb_alu_exec_cluster;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  issue_valid;
    logic [11:0] optype_issue;
    logic [95:0] PC_issue, srcReg1_data_issue, srcReg2_data_issue, imm_issue;
    logic [17:0] destReg_issue;
    logic [47:0] ROBNum_issue;
    logic        FU_ready_ALU0_out, FU_ready_ALU1_out, FU_ready_ALU2_out;
    logic        wb_valid, wb_ready;
    logic [1:0]  wb_lane;
    logic [31:0] wb_result, wb_PC, wb_store_data;
    logic [5:0]  wb_destReg;
    logic [15:0] wb_ROBNum;
    logic        wb_rd_en, wb_is_mem, illegal_op;

    alu_exec_cluster #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .optype_issue(optype_issue), .PC_issue(PC_issue),
        .srcReg1_data_issue(srcReg1_data_issue), .srcReg2_data_issue(srcReg2_data_issue),
        .imm_issue(imm_issue), .destReg_issue(destReg_issue), .ROBNum_issue(ROBNum_issue),
        .FU_ready_ALU0_out(FU_ready_ALU0_out), .FU_ready_ALU1_out(FU_ready_ALU1_out),
        .FU_ready_ALU2_out(FU_ready_ALU2_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_lane(wb_lane), .wb_result(wb_result),
        .wb_destReg(wb_destReg), .wb_ROBNum(wb_ROBNum), .wb_PC(wb_PC), .wb_rd_en(wb_rd_en),
        .wb_is_mem(wb_is_mem), .wb_store_data(wb_store_data), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  dest;
        logic [15:0] rob;
        logic [31:0] pc;
        logic        rd_en;
        logic        is_mem;
        logic [31:0] sdata;
    } ent_t;

    ent_t q [3][$];
    int   m_ptr;
    bit   m_held;
    int   m_held_lane;
    bit   m_ill;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sra(input logic [31:0] v, input logic [4:0] sh);
        if (v[31]) return ~((~v) >> sh);
        return v >> sh;
    endfunction

    function automatic bit legal(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd10;
    endfunction

    function automatic ent_t mk(input logic [3:0] op, input logic [31:0] s1, s2, imm,
                                input logic [5:0] d, input logic [15:0] rob, input logic [31:0] pc);
        ent_t e;
        e.dest = d; e.rob = rob; e.pc = pc;
        e.rd_en = !(op == 4'd9 || op == 4'd10);
        e.is_mem = op >= 4'd7 && op <= 4'd10;
        e.sdata = (op == 4'd9 || op == 4'd10) ? s2 : 32'd0;
        case (op)
            4'd1:    e.res = s1 + s2;
            4'd2:    e.res = s1 + imm;
            4'd3:    e.res = imm;
            4'd4:    e.res = s1 | imm;
            4'd5:    e.res = s1 ^ s2;
            4'd6:    e.res = sra(s1, imm[4:0]);
            default: e.res = s1 + imm;
        endcase
        return e;
    endfunction

    task automatic present(output bit v, output int l);
        v = 0; l = 0;
        if (m_held) begin
            v = 1; l = m_held_lane;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!v && q[(m_ptr + i) % 3].size() > 0) begin
                    v = 1; l = (m_ptr + i) % 3;
                end
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) q[k].delete();
        m_ptr = 0; m_held = 0; m_held_lane = 0; m_ill = 0;
    endtask

    task automatic model_edge();
        bit v; int l; bit fu [3];
        present(v, l);
        for (int k = 0; k < 3; k++) fu[k] = q[k].size() < D;
        m_ill = 0;
        if (v && wb_ready) begin
            void'(q[l].pop_front());
            m_ptr = (l + 1) % 3;
            m_held = 0;
        end else if (v) begin
            m_held = 1; m_held_lane = l;
        end else m_held = 0;
        for (int k = 0; k < 3; k++) begin
            if (issue_valid[k] && fu[k]) begin
                if (legal(optype_issue[4*k +: 4]))
                    q[k].push_back(mk(optype_issue[4*k +: 4], srcReg1_data_issue[32*k +: 32],
                                      srcReg2_data_issue[32*k +: 32], imm_issue[32*k +: 32],
                                      destReg_issue[6*k +: 6], ROBNum_issue[16*k +: 16],
                                      PC_issue[32*k +: 32]));
                else m_ill = 1;
            end
        end
    endtask

    task automatic model_check();
        bit v; int l;
        present(v, l);
        chk("wb_valid", wb_valid, v);
        chk("fu_ready0", FU_ready_ALU0_out, !rst && q[0].size() < D);
        chk("fu_ready1", FU_ready_ALU1_out, !rst && q[1].size() < D);
        chk("fu_ready2", FU_ready_ALU2_out, !rst && q[2].size() < D);
        chk("illegal_op", illegal_op, m_ill);
        if (v) begin
            chk("wb_lane", wb_lane, l);
            chk("wb_result", wb_result, q[l][0].res);
            chk("wb_destReg", wb_destReg, q[l][0].dest);
            chk("wb_ROBNum", wb_ROBNum, q[l][0].rob);
            chk("wb_PC", wb_PC, q[l][0].pc);
            chk("wb_rd_en", wb_rd_en, q[l][0].rd_en);
            chk("wb_is_mem", wb_is_mem, q[l][0].is_mem);
            chk("wb_store_data", wb_store_data, q[l][0].sdata);
        end
    endtask

    task automatic step();
        if (rst) model_clear();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        model_check();
    endtask

    task automatic set_lane(input int k, input logic [3:0] op, input logic [31:0] s1, s2, imm,
                            input logic [5:0] d, input logic [15:0] rob, input logic [31:0] pc);
        issue_valid[k]               = 1'b1;
        optype_issue[4*k +: 4]       = op;
        srcReg1_data_issue[32*k +: 32] = s1;
        srcReg2_data_issue[32*k +: 32] = s2;
        imm_issue[32*k +: 32]        = imm;
        destReg_issue[6*k +: 6]      = d;
        ROBNum_issue[16*k +: 16]     = rob;
        PC_issue[32*k +: 32]         = pc;
    endtask

    task automatic set_rand_lane(input int k);
        logic [3:0] op;
        int r;
        if ($urandom_range(0, 9) == 0) begin
            r  = $urandom_range(0, 5);
            op = (r == 0) ? 4'd0 : 4'(10 + r);
        end else op = 4'($urandom_range(1, 10));
        set_lane(k, op, $urandom, $urandom, $urandom, 6'($urandom), 16'($urandom), $urandom);
        issue_valid[k] = ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        rst = 1'b1; wb_ready = 1'b0; issue_valid = '0; optype_issue = '0;
        PC_issue = '0; srcReg1_data_issue = '0; srcReg2_data_issue = '0; imm_issue = '0;
        destReg_issue = '0; ROBNum_issue = '0;
        step(); step();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fu0", FU_ready_ALU0_out, 0);
        chk("rst_result", wb_result, 0);
        rst = 1'b0; wb_ready = 1'b1;
        step();
        chk("post_rst_fu1", FU_ready_ALU1_out, 1);

        set_lane(0, 4'd1, 32'd5, 32'd7, 32'd0, 6'd3, 16'd9, 32'h1000);
        step();
        chk("add_valid", wb_valid, 1);
        chk("add_result", wb_result, 32'd12);
        chk("add_dest", wb_destReg, 6'd3);
        chk("add_rob", wb_ROBNum, 16'd9);
        chk("add_rd_en", wb_rd_en, 1);
        chk("add_lane", wb_lane, 0);

        issue_valid = '0;
        set_lane(1, 4'd6, 32'h8000_0000, 32'd0, 32'd4, 6'd4, 16'd10, 32'h1004);
        set_lane(2, 4'd10, 32'h100, 32'hAB, 32'd8, 6'd5, 16'd11, 32'h1008);
        step();
        chk("srai_result", wb_result, 32'hF800_0000);
        issue_valid = '0;
        step();
        chk("sw_result", wb_result, 32'h108);
        chk("sw_is_mem", wb_is_mem, 1);
        chk("sw_rd_en", wb_rd_en, 0);
        chk("sw_sdata", wb_store_data, 32'hAB);
        step();

        wb_ready = 1'b0;
        set_lane(0, 4'd1, 32'd1, 32'd2, 32'd0, 6'd6, 16'd20, 32'h2000); step();
        set_lane(0, 4'd1, 32'd3, 32'd4, 32'd0, 6'd7, 16'd21, 32'h2004); step();
        chk("full_fu0", FU_ready_ALU0_out, 0);
        set_lane(0, 4'd5, 32'hF, 32'hF0, 32'd0, 6'd8, 16'd22, 32'h2008); step();
        chk("full_head_hold", wb_result, 32'd3);
        issue_valid = '0; wb_ready = 1'b1;
        step();
        chk("full_second", wb_result, 32'd7);
        step();
        chk("full_fu0_back", FU_ready_ALU0_out, 1);
        chk("full_drained", wb_valid, 0);

        set_lane(2, 4'd3, 32'd0, 32'd0, 32'h5000, 6'd9, 16'd30, 32'h3000); step();
        issue_valid = '0; step();
        for (int k = 0; k < 3; k++) set_lane(k, 4'd2, 32'(k), 32'd0, 32'd100, 6'(k), 16'(40 + k), 32'h4000);
        step(); chk("rr0_first", wb_lane, 0);
        issue_valid = '0;
        step(); chk("rr0_second", wb_lane, 1);
        step(); chk("rr0_third", wb_lane, 2);
        step();

        set_lane(1, 4'd4, 32'h10, 32'd0, 32'h1, 6'd1, 16'd50, 32'h5000); step();
        issue_valid = '0; step();
        for (int k = 0; k < 3; k++) set_lane(k, 4'd8, 32'h200, 32'd0, 32'(k), 6'(k), 16'(60 + k), 32'h6000);
        step(); chk("rr2_first", wb_lane, 2);
        issue_valid = '0;
        step(); chk("rr2_second", wb_lane, 0);
        step(); chk("rr2_third", wb_lane, 1);
        step();

        set_lane(1, 4'd0, 32'd1, 32'd1, 32'd1, 6'd1, 16'd1, 32'd0); step();
        chk("ill_pulse", illegal_op, 1);
        chk("ill_no_wb", wb_valid, 0);
        chk("ill_fu1", FU_ready_ALU1_out, 1);
        issue_valid = '0; step();
        chk("ill_clear", illegal_op, 0);

        wb_ready = 1'b0;
        set_lane(0, 4'd1, 32'd8, 32'd8, 32'd0, 6'd2, 16'd70, 32'h7000); step();
        set_lane(0, 4'd1, 32'd9, 32'd9, 32'd0, 6'd3, 16'd71, 32'h7004); step();
        issue_valid = '0; rst = 1'b1;
        step();
        chk("mid_rst_valid", wb_valid, 0);
        chk("mid_rst_fu2", FU_ready_ALU2_out, 0);
        rst = 1'b0; step();
        chk("rel_fu0", FU_ready_ALU0_out, 1);
        wb_ready = 1'b1; step();
        chk("rel_no_stale", wb_valid, 0);

        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 3; k++) set_rand_lane(k);
            wb_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 149) == 0);
            step();
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
